// File: rtl/vx_ti_trav_stack_if.sv
// Request/response bus between the traversal controller and the multi-lane stack.
interface vx_ti_trav_stack_if #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned DATA_W    = 32
);
  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic              req_valid;
  logic              req_ready;
  logic [LANE_W-1:0] req_lane;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_data0;
  logic [DATA_W-1:0] req_data1;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [LANE_W-1:0] rsp_lane;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_empty;
  logic              rsp_ovf;

  // Traversal controller side
  modport master (
    output req_valid, req_lane, req_op, req_data0, req_data1, rsp_ready,
    input  req_ready, rsp_valid, rsp_lane, rsp_data, rsp_empty, rsp_ovf
  );

  // Stack side
  modport slave (
    input  req_valid, req_lane, req_op, req_data0, req_data1, rsp_ready,
    output req_ready, rsp_valid, rsp_lane, rsp_data, rsp_empty, rsp_ovf
  );
endinterface

// File: rtl/vx_ti_trav_stack.sv
// Multi-lane BVH traversal short stack: NUM_LANES independent circular stacks
// behind one request/response port. Overflow drops the oldest entry and sets a
// sticky per-lane flag so the controller can restart that ray from the root.
module vx_ti_trav_stack #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_ti_trav_stack_if.slave    bus,
  output logic [NUM_LANES-1:0] empty_mask_o,
  output logic [NUM_LANES-1:0] ovf_mask_o
);

  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    OP_INIT  = 2'b00,
    OP_PUSH  = 2'b01,
    OP_PUSH2 = 2'b10,
    OP_POP   = 2'b11
  } op_e;

  logic [DATA_W-1:0]    mem_q [NUM_LANES][DEPTH];
  logic [PTR_W-1:0]     tp_q  [NUM_LANES];
  logic [PTR_W-1:0]     tp_d  [NUM_LANES];
  logic [CNT_W-1:0]     cnt_q [NUM_LANES];
  logic [CNT_W-1:0]     cnt_d [NUM_LANES];
  logic [NUM_LANES-1:0] ovf_q, ovf_d;
  logic [NUM_LANES-1:0] empty_mask_q;

  logic                 rsp_valid_q, rsp_valid_d;
  logic [LANE_W-1:0]    rsp_lane_q, rsp_lane_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_empty_q, rsp_empty_d;
  logic                 rsp_ovf_q, rsp_ovf_d;

  logic [NUM_LANES-1:0] we0, we1;
  logic [PTR_W-1:0]     waddr0, waddr1;
  logic                 accept;

  assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_lane  = rsp_lane_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_empty = rsp_empty_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign empty_mask_o  = empty_mask_q;
  assign ovf_mask_o    = ovf_q;

  // Next-state for the addressed lane and the pop response; unmatched lanes are ignored
  always_comb begin
    tp_d        = tp_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    we0         = '0;
    we1         = '0;
    waddr0      = '0;
    waddr1      = '0;
    rsp_valid_d = rsp_valid_q && !bus.rsp_ready;
    rsp_lane_d  = rsp_lane_q;
    rsp_data_d  = rsp_data_q;
    rsp_empty_d = rsp_empty_q;
    rsp_ovf_d   = rsp_ovf_q;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (accept && bus.req_lane == LANE_W'(l)) begin
        case (bus.req_op)
          OP_INIT: begin
            we0[l]   = 1'b1;
            waddr0   = '0;
            tp_d[l]  = PTR_W'(1);
            cnt_d[l] = CNT_W'(1);
            ovf_d[l] = 1'b0;
          end
          OP_PUSH: begin
            we0[l]  = 1'b1;
            waddr0  = tp_q[l];
            tp_d[l] = tp_q[l] + PTR_W'(1);
            if (cnt_q[l] == CNT_W'(DEPTH)) begin
              ovf_d[l] = 1'b1;
            end else begin
              cnt_d[l] = cnt_q[l] + CNT_W'(1);
            end
          end
          OP_PUSH2: begin
            we0[l]  = 1'b1;
            we1[l]  = 1'b1;
            waddr0  = tp_q[l];
            waddr1  = tp_q[l] + PTR_W'(1);
            tp_d[l] = tp_q[l] + PTR_W'(2);
            if (cnt_q[l] >= CNT_W'(DEPTH - 1)) begin
              cnt_d[l] = CNT_W'(DEPTH);
              ovf_d[l] = 1'b1;
            end else begin
              cnt_d[l] = cnt_q[l] + CNT_W'(2);
            end
          end
          default: begin
            rsp_valid_d = 1'b1;
            rsp_lane_d  = LANE_W'(l);
            rsp_ovf_d   = ovf_q[l];
            if (cnt_q[l] != '0) begin
              rsp_data_d  = mem_q[l][tp_q[l] - PTR_W'(1)];
              rsp_empty_d = 1'b0;
              tp_d[l]     = tp_q[l] - PTR_W'(1);
              cnt_d[l]    = cnt_q[l] - CNT_W'(1);
            end else begin
              rsp_data_d  = '0;
              rsp_empty_d = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Pointer, count, flag and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        tp_q[l]  <= '0;
        cnt_q[l] <= '0;
      end
      ovf_q        <= '0;
      empty_mask_q <= '1;
      rsp_valid_q  <= 1'b0;
      rsp_lane_q   <= '0;
      rsp_data_q   <= '0;
      rsp_empty_q  <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        tp_q[l]         <= tp_d[l];
        cnt_q[l]        <= cnt_d[l];
        empty_mask_q[l] <= (cnt_d[l] == '0);
      end
      ovf_q       <= ovf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_lane_q  <= rsp_lane_d;
      rsp_data_q  <= rsp_data_d;
      rsp_empty_q <= rsp_empty_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  // Stack storage; contents are meaningful only below the lane's count
  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (we0[l]) mem_q[l][waddr0] <= bus.req_data0;
      if (we1[l]) mem_q[l][waddr1] <= bus.req_data1;
    end
  end

endmodule

// File: tb/tb_vx_ti_trav_stack.sv
// Scoreboard bench for vx_ti_trav_stack: a queue-based per-lane stack model
// predicts every pop response; directed tasks cover masks, backpressure and reset.
module tb_vx_ti_trav_stack;

  localparam int unsigned NL = 5;
  localparam int unsigned DP = 4;
  localparam int unsigned LW = 3;
  localparam logic [1:0] OP_INIT  = 2'b00;
  localparam logic [1:0] OP_PUSH  = 2'b01;
  localparam logic [1:0] OP_PUSH2 = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  typedef struct packed {
    logic [LW-1:0] lane;
    logic [31:0]   data;
    logic          empty;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NL-1:0] empty_mask, ovf_mask;

  vx_ti_trav_stack_if #(.NUM_LANES(NL), .DATA_W(32)) bus ();

  vx_ti_trav_stack #(.NUM_LANES(NL), .DEPTH(DP), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .empty_mask_o (empty_mask),
    .ovf_mask_o   (ovf_mask)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];
  logic [31:0] mq [NL][$];
  bit movf [NL];

  function automatic void model_reset();
    for (int i = 0; i < NL; i++) begin
      mq[i].delete();
      movf[i] = 1'b0;
    end
    sb.delete();
  endfunction

  function automatic void model_apply(input int lane, input logic [1:0] op,
                                      input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    if (lane >= NL) return;
    case (op)
      OP_INIT: begin
        mq[lane].delete();
        mq[lane].push_back(d0);
        movf[lane] = 1'b0;
      end
      OP_PUSH, OP_PUSH2: begin
        mq[lane].push_back(d0);
        if (op == OP_PUSH2) mq[lane].push_back(d1);
        while (mq[lane].size() > DP) begin
          void'(mq[lane].pop_front());
          movf[lane] = 1'b1;
        end
      end
      default: begin
        e.lane = LW'(lane);
        e.ovf  = movf[lane];
        if (mq[lane].size() > 0) begin
          e.data  = mq[lane].pop_back();
          e.empty = 1'b0;
        end else begin
          e.data  = 32'd0;
          e.empty = 1'b1;
        end
        sb.push_back(e);
      end
    endcase
  endfunction

  function automatic logic [NL-1:0] model_empty();
    logic [NL-1:0] r;
    for (int i = 0; i < NL; i++) r[i] = (mq[i].size() == 0);
    return r;
  endfunction

  function automatic logic [NL-1:0] model_ovf();
    logic [NL-1:0] r;
    for (int i = 0; i < NL; i++) r[i] = movf[i];
    return r;
  endfunction

  // Scoreboard: compare each response in the cycle the consumer takes it
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.rsp_valid && bus.rsp_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected lane=%0d data=%0d empty=%0b", bus.rsp_lane, bus.rsp_data, bus.rsp_empty);
      end else begin
        e = sb.pop_front();
        if ({bus.rsp_lane, bus.rsp_data, bus.rsp_empty, bus.rsp_ovf} !== e) begin
          n_err++;
          $display("FAIL rsp lane/data/empty/ovf got %0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b",
                   bus.rsp_lane, bus.rsp_data, bus.rsp_empty, bus.rsp_ovf,
                   e.lane, e.data, e.empty, e.ovf);
        end
      end
    end
  end

  // Present one request from posedge+1; returns at posedge+1 after acceptance
  task automatic issue(input int lane, input logic [1:0] op, input logic [31:0] d0,
                       input logic [31:0] d1, output int waits);
    bus.req_valid = 1'b1;
    bus.req_lane  = LW'(lane);
    bus.req_op    = op;
    bus.req_data0 = d0;
    bus.req_data1 = d1;
    waits = 0;
    @(negedge clk);
    while (!bus.req_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout lane=%0d op=%0d ready=%0b want 1", lane, op, bus.req_ready);
    end else begin
      model_apply(lane, op, d0, d1);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    n_vec++;
    if ({bus.rsp_valid, bus.rsp_lane, bus.rsp_data, bus.rsp_empty, bus.rsp_ovf} !== '0) begin
      n_err++;
      $display("FAIL reset_rsp got v=%0b l=%0d d=%0d e=%0b o=%0b want all 0",
               bus.rsp_valid, bus.rsp_lane, bus.rsp_data, bus.rsp_empty, bus.rsp_ovf);
    end
    n_vec++;
    if (empty_mask !== 5'b11111 || ovf_mask !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_masks got empty=%b ovf=%b want 11111/00000", empty_mask, ovf_mask);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready got ready=%0b valid=%0b want 1/0", bus.req_ready, bus.rsp_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_init_pop();
    int w;
    issue(0, OP_INIT, 32'd5, 32'd0, w);
    n_vec++;
    if (empty_mask[0] !== 1'b0) begin
      n_err++;
      $display("FAIL init_empty_mask got %0b want 0", empty_mask[0]);
    end
    issue(0, OP_POP, 32'd0, 32'd0, w);
    issue(0, OP_POP, 32'd0, 32'd0, w);
    n_vec++;
    if (empty_mask[0] !== 1'b1) begin
      n_err++;
      $display("FAIL pop_empty_mask got %0b want 1", empty_mask[0]);
    end
  endtask

  task automatic test_push2();
    int w;
    issue(1, OP_PUSH2, 32'd7, 32'd9, w);
    n_vec++;
    if (ovf_mask[1] !== 1'b0 || empty_mask[1] !== 1'b0) begin
      n_err++;
      $display("FAIL push2_masks got ovf=%0b empty=%0b want 0/0", ovf_mask[1], empty_mask[1]);
    end
    repeat (3) issue(1, OP_POP, 32'd0, 32'd0, w);
    n_vec++;
    if (ovf_mask[1] !== 1'b0 || empty_mask[1] !== 1'b1) begin
      n_err++;
      $display("FAIL push2_after_pops got ovf=%0b empty=%0b want 0/1", ovf_mask[1], empty_mask[1]);
    end
  endtask

  task automatic test_overflow();
    int w;
    issue(2, OP_INIT, 32'd1, 32'd0, w);
    for (int v = 2; v <= 5; v++) issue(2, OP_PUSH, 32'(v), 32'd0, w);
    n_vec++;
    if (ovf_mask[2] !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set got %0b want 1", ovf_mask[2]);
    end
    repeat (5) issue(2, OP_POP, 32'd0, 32'd0, w);
    n_vec++;
    if (ovf_mask[2] !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky got %0b want 1", ovf_mask[2]);
    end
    issue(2, OP_INIT, 32'd1, 32'd0, w);
    n_vec++;
    if (ovf_mask[2] !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_init_clear got %0b want 0", ovf_mask[2]);
    end
    // PUSH2 at count DEPTH-1 loses exactly one entry
    issue(2, OP_PUSH, 32'd2, 32'd0, w);
    issue(2, OP_PUSH, 32'd3, 32'd0, w);
    n_vec++;
    if (ovf_mask[2] !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_before_push2 got %0b want 0", ovf_mask[2]);
    end
    issue(2, OP_PUSH2, 32'd4, 32'd5, w);
    n_vec++;
    if (ovf_mask[2] !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_push2_dm1 got %0b want 1", ovf_mask[2]);
    end
    repeat (5) issue(2, OP_POP, 32'd0, 32'd0, w);
    // PUSH2 at full loses two entries
    issue(1, OP_INIT, 32'd1, 32'd0, w);
    issue(1, OP_PUSH2, 32'd2, 32'd3, w);
    issue(1, OP_PUSH, 32'd4, 32'd0, w);
    issue(1, OP_PUSH2, 32'd5, 32'd6, w);
    repeat (5) issue(1, OP_POP, 32'd0, 32'd0, w);
  endtask

  task automatic test_backpressure();
    int w;
    issue(0, OP_INIT, 32'd11, 32'd0, w);
    issue(0, OP_PUSH, 32'd12, 32'd0, w);
    bus.rsp_ready = 1'b0;
    issue(0, OP_POP, 32'd0, 32'd0, w);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++;
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd12 ||
          bus.rsp_lane !== 3'd0 || bus.rsp_empty !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold c=%0d got ready=%0b valid=%0b data=%0d lane=%0d want 0/1/12/0",
                 c, bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_lane);
      end
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    issue(0, OP_POP, 32'd0, 32'd0, w);
    n_vec++;
    if (w != 0) begin
      n_err++;
      $display("FAIL bp_release_accept got waits=%0d want 0", w);
    end
  endtask

  task automatic test_isolation();
    int w;
    issue(0, OP_PUSH, 32'd10, 32'd0, w);
    issue(3, OP_PUSH, 32'd30, 32'd0, w);
    issue(3, OP_POP, 32'd0, 32'd0, w);
    issue(0, OP_POP, 32'd0, 32'd0, w);
    issue(5, OP_PUSH, 32'd99, 32'd0, w);
    issue(5, OP_POP, 32'd0, 32'd0, w);
    @(negedge clk);
    n_vec++;
    if (bus.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bad_lane_rsp got valid=%0b want 0", bus.rsp_valid);
    end
    n_vec++;
    if (empty_mask !== model_empty() || ovf_mask !== model_ovf()) begin
      n_err++;
      $display("FAIL bad_lane_masks got empty=%b ovf=%b want %b/%b",
               empty_mask, ovf_mask, model_empty(), model_ovf());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int w;
    int stalls;
    issue(4, OP_PUSH2, 32'd41, 32'd42, w);
    issue(4, OP_PUSH2, 32'd43, 32'd44, w);
    stalls = 0;
    for (int k = 0; k < 5; k++) begin
      issue(4, OP_POP, 32'd0, 32'd0, w);
      stalls += w;
    end
    n_vec++;
    if (stalls != 0) begin
      n_err++;
      $display("FAIL b2b_stalls got %0d want 0", stalls);
    end
    n_vec++;
    if (ovf_mask[4] !== 1'b0 || empty_mask[4] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_masks got ovf=%0b empty=%0b want 0/1", ovf_mask[4], empty_mask[4]);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    issue(0, OP_PUSH, 32'd77, 32'd0, w);
    bus.rsp_ready = 1'b0;
    issue(0, OP_POP, 32'd0, 32'd0, w);
    n_vec++;
    if (bus.rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre_valid got %0b want 1", bus.rsp_valid);
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (bus.rsp_valid !== 1'b0 || empty_mask !== 5'b11111 || ovf_mask !== 5'b00000) begin
      n_err++;
      $display("FAIL mid_reset got valid=%0b empty=%b ovf=%b want 0/11111/00000",
               bus.rsp_valid, empty_mask, ovf_mask);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    issue(0, OP_POP, 32'd0, 32'd0, w);
    issue(2, OP_POP, 32'd0, 32'd0, w);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_lane  = '0;
    bus.req_op    = OP_INIT;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    bus.rsp_ready = 1'b1;
    model_reset();
    test_reset();
    test_init_pop();
    test_push2();
    test_overflow();
    test_backpressure();
    test_isolation();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
